conv_window_seq: RTL

Sequencer that takes over the input-sample memory write controller once the memory is loaded and walks it through every 1-D convolution window. For each of the N−M+1 output positions it loads the window base address, steps the address through M taps in lock-step with the filter-tap address, and hands each tap to the MAC stage over a valid/ready handshake. It sits between the loaded input/filter memories and the accumulator, driving the write controller's external address-control inputs.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/conv_stall_counter.sv | 19 +
 rtl/conv_window_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared types and defaults for the 1-D convolution window sequencer.
package cnn_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStep,
        StDone
    } seq_state_e;

    localparam int unsigned N_DEFAULT = 16;
    localparam int unsigned M_DEFAULT = 4;

    // Address width for a memory of the given depth, never narrower than one bit
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/conv_stall_counter.sv
// Saturating 16-bit count of cycles the MAC stage held off a presented tap.
module conv_stall_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        inc,
    output logic [15:0] count
);

    // Clear on reset or new pass, otherwise count stalls and stick at all-ones
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/conv_window_seq.sv
// Walks the loaded sample memory through every 1-D convolution window,
// stepping sample and filter-tap addresses together and presenting each tap
// to the MAC stage over valid/ready.
// Optional feature: CONV_SEQ_STALL_CNT_EN adds the stall_cnt output.
module conv_window_seq
    import cnn_pkg::*;
#(
    parameter int unsigned N        = N_DEFAULT,
    parameter int unsigned M        = M_DEFAULT,
    parameter int unsigned ADDR_W   = addr_width(N),
    parameter int unsigned F_ADDR_W = addr_width(M)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                m_ready,
    output logic                en_ext_ctrl,
    output logic                ext_load_addr,
    output logic [ADDR_W-1:0]   ext_load_addr_val,
    output logic                ext_incr_addr,
    output logic [F_ADDR_W-1:0] f_addr,
    output logic                tap_valid,
    output logic                tap_last,
    output logic                busy,
`ifdef CONV_SEQ_STALL_CNT_EN
    output logic [15:0]         stall_cnt,
`endif
    output logic                done
);

    localparam logic [F_ADDR_W-1:0] TAP_LAST  = F_ADDR_W'(M - 1);
    localparam logic [ADDR_W-1:0]   BASE_LAST = ADDR_W'(N - M);

    seq_state_e          state;
    logic [ADDR_W-1:0]   base;
    logic [F_ADDR_W-1:0] tap;

    // State and window/tap counters; everything advances only on an accepted tap
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
            base  <= '0;
            tap   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state <= StLoad;
                        base  <= '0;
                        tap   <= '0;
                    end
                end
                StLoad: state <= StStep;
                StStep: begin
                    if (m_ready) begin
                        if (tap != TAP_LAST) begin
                            tap <= tap + 1'b1;
                        end else if (base != BASE_LAST) begin
                            base <= base + 1'b1;
                            tap  <= '0;
                        end else begin
                            state <= StDone;
                        end
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Output decode from registered state/counters and m_ready only
    always_comb begin
        en_ext_ctrl       = 1'b0;
        ext_load_addr     = 1'b0;
        ext_load_addr_val = '0;
        ext_incr_addr     = 1'b0;
        f_addr            = '0;
        tap_valid         = 1'b0;
        tap_last          = 1'b0;
        busy              = 1'b0;
        done              = 1'b0;
        unique case (state)
            StLoad: begin
                en_ext_ctrl   = 1'b1;
                ext_load_addr = 1'b1;
                busy          = 1'b1;
            end
            StStep: begin
                en_ext_ctrl = 1'b1;
                busy        = 1'b1;
                tap_valid   = 1'b1;
                f_addr      = tap;
                tap_last    = (tap == TAP_LAST);
                if (m_ready) begin
                    if (tap != TAP_LAST) begin
                        ext_incr_addr = 1'b1;
                    end else if (base != BASE_LAST) begin
                        // Next window base replaces the increment: no bubble between windows
                        ext_load_addr     = 1'b1;
                        ext_load_addr_val = base + 1'b1;
                    end
                end
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

`ifdef CONV_SEQ_STALL_CNT_EN
    conv_stall_counter u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .clear ((state == StIdle) && start),
        .inc   ((state == StStep) && !m_ready),
        .count (stall_cnt)
    );
`endif

endmodule
